// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared defaults, packer state type and row-entry layout
package sa_pkg;

    localparam int SA_DATA_WIDTH = 32;
    localparam int SA_LANES      = 4;
    localparam int SA_FIFO_DEPTH = 8;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FILL  = 1'b1
    } pk_state_e;

    // Field order matches the {last, mask, row} word stored in the row FIFO.
    typedef struct packed {
        logic                              last;
        logic [SA_LANES-1:0]               mask;
        logic [SA_LANES*SA_DATA_WIDTH-1:0] row;
    } sa_row_entry_t;

endpackage

// File: rtl/sa_row_fifo.sv
// rtl/sa_row_fifo.sv - first-word-fall-through row FIFO
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (clears pointers)
//   push_i, data_i    write an entry (ignored when full)
//   pop_i             drop the head entry (ignored when empty)
//   head_o            head entry straight from storage, zero when empty
//   full_o, empty_o   occupancy flags from the registered pointers
module sa_row_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra MSB so full and empty differ when indices match.
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Stale storage is masked so the head reads zero whenever nothing is queued.
    assign head_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/sa_row_packer.sv
// rtl/sa_row_packer.sv - packs AXI write beats into systolic-array rows
//
// Ports:
//   ACLK, ARESETN                 clock, asynchronous active-low reset
//   s_wdata/s_wvalid/s_wlast      incoming write beats, s_wready = room in FIFO
//   m_row/m_mask/m_last/m_valid   head row of the FIFO, consumed with m_ready
//   row_count                     rows pushed since reset (wraps)
module sa_row_packer
    import sa_pkg::*;
#(
    parameter int DATA_WIDTH = SA_DATA_WIDTH,
    parameter int LANES      = SA_LANES,
    parameter int FIFO_DEPTH = SA_FIFO_DEPTH
) (
    input  logic                        ACLK,
    input  logic                        ARESETN,
    input  logic [DATA_WIDTH-1:0]       s_wdata,
    input  logic                        s_wvalid,
    input  logic                        s_wlast,
    output logic                        s_wready,
    output logic [LANES*DATA_WIDTH-1:0] m_row,
    output logic [LANES-1:0]            m_mask,
    output logic                        m_last,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [15:0]                 row_count
);

    localparam int ROW_W   = LANES * DATA_WIDTH;
    localparam int ENTRY_W = ROW_W + LANES + 1;
    localparam int LIDX_W  = (LANES > 1) ? $clog2(LANES) : 1;

    pk_state_e         state_q;
    logic [LIDX_W-1:0] lane_idx_q;
    logic [ROW_W-1:0]  stage_q;
    logic [LANES-1:0]  mask_q;
    logic [15:0]       row_count_q;
    logic              ready_en_q;

    logic [ROW_W-1:0]   row_d;
    logic [LANES-1:0]   mask_d;
    logic               accept;
    logic               at_end;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head;

    // ready_en_q holds s_wready low through reset and the first edge after it.
    assign s_wready  = ready_en_q & ~fifo_full;
    assign accept    = s_wvalid & s_wready;
    assign at_end    = (lane_idx_q == LIDX_W'(LANES - 1));
    assign push      = accept & (at_end | s_wlast);
    assign m_valid   = ~fifo_empty;
    assign pop       = m_valid & m_ready;
    assign row_count = row_count_q;

    // Staged row with the current beat dropped into its lane; this is both the
    // pushed row and the next staging value.
    always_comb begin
        row_d  = (state_q == ST_FILL) ? stage_q : '0;
        mask_d = ((state_q == ST_FILL) ? mask_q : '0) | (LANES'(1) << lane_idx_q);
        row_d[int'(lane_idx_q)*DATA_WIDTH +: DATA_WIDTH] = s_wdata;
    end

    // A full row carries s_wlast; a short row only closes on s_wlast=1.
    assign push_entry = {s_wlast, mask_d, row_d};

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= ST_EMPTY;
            lane_idx_q  <= '0;
            stage_q     <= '0;
            mask_q      <= '0;
            row_count_q <= '0;
            ready_en_q  <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            if (push) row_count_q <= row_count_q + 16'd1;
            if (accept) begin
                if (push) begin
                    state_q    <= ST_EMPTY;
                    lane_idx_q <= '0;
                    stage_q    <= '0;
                    mask_q     <= '0;
                end else begin
                    state_q    <= ST_FILL;
                    lane_idx_q <= lane_idx_q + LIDX_W'(1);
                    stage_q    <= row_d;
                    mask_q     <= mask_d;
                end
            end
        end
    end

    sa_row_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (ACLK),
        .rst_n   (ARESETN),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign {m_last, m_mask, m_row} = head;

endmodule

// File: tb/tb_sa_row_packer.sv
// tb/tb_sa_row_packer.sv - randomized self-checking bench for sa_row_packer
module tb_sa_row_packer;
    import sa_pkg::*;

    localparam int DW = SA_DATA_WIDTH;
    localparam int LN = SA_LANES;

    logic            ACLK = 1'b0;
    logic            ARESETN = 1'b0;
    logic [DW-1:0]   s_wdata = '0;
    logic            s_wvalid = 1'b0;
    logic            s_wlast = 1'b0;
    logic            s_wready;
    logic [LN*DW-1:0] m_row;
    logic [LN-1:0]   m_mask;
    logic            m_last;
    logic            m_valid;
    logic            m_ready = 1'b0;
    logic [15:0]     row_count;

    int n_cmp = 0;
    int n_err = 0;
    int total_rows = 0;
    int ready_mode = 1;    // 0: stall, 1: always ready, 2: random

    sa_row_entry_t exp_q[$];
    logic [DW-1:0] burst_q[$];

    sa_row_packer dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .s_wdata   (s_wdata),
        .s_wvalid  (s_wvalid),
        .s_wlast   (s_wlast),
        .s_wready  (s_wready),
        .m_row     (m_row),
        .m_mask    (m_mask),
        .m_last    (m_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .row_count (row_count)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: a burst is cut into LANES-word chunks, the last chunk closes it.
    task automatic model_burst();
        sa_row_entry_t e;
        int n = burst_q.size();
        for (int b = 0; b < n; b += LN) begin
            e = '0;
            for (int k = 0; k < LN && b + k < n; k++) begin
                e.row[k*DW +: DW] = burst_q[b+k];
                e.mask[k] = 1'b1;
            end
            e.last = (b + LN >= n);
            exp_q.push_back(e);
            total_rows++;
        end
    endtask

    // Consumer and scoreboard, acting on the falling edge.
    sa_row_entry_t mon_e;
    logic [159:0]  held;
    logic          hold_pending = 1'b0;

    always @(negedge ACLK) begin
        case (ready_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
        if (ARESETN) begin
            if (hold_pending && m_valid)
                check("hold_stable", {m_last, m_mask, m_row}, held);
            if (m_valid && m_ready) begin
                check("row_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("row", m_row, mon_e.row);
                    check("mask", m_mask, mon_e.mask);
                    check("last", m_last, mon_e.last);
                end
            end
            hold_pending = m_valid && !m_ready;
            held = {m_last, m_mask, m_row};
        end else begin
            hold_pending = 1'b0;
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_word(input logic [DW-1:0] d, input logic l);
        int n = 0;
        s_wdata  = d;
        s_wvalid = 1'b1;
        s_wlast  = l;
        while (!s_wready && n < 1000) begin
            @(negedge ACLK);
            n++;
        end
        check("wready_wait", n >= 1000, 1'b0);
        @(negedge ACLK);
    endtask

    task automatic send_burst();
        model_burst();
        for (int i = 0; i < burst_q.size(); i++)
            send_word(burst_q[i], i == burst_q.size() - 1);
        s_wvalid = 1'b0;
        s_wlast  = 1'b0;
    endtask

    task automatic set_mode(input int m);
        @(posedge ACLK);
        #1 ready_mode = m;
        @(negedge ACLK);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || m_valid) && n < 2000) begin
            @(negedge ACLK);
            n++;
        end
        check("drain_in_time", n < 2000, 1'b1);
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;

        // Reset values
        #1;
        check("rst_wready", s_wready, 0);
        check("rst_mvalid", m_valid, 0);
        check("rst_mrow", m_row, 0);
        check("rst_mmask", m_mask, 0);
        check("rst_mlast", m_last, 0);
        check("rst_rowcount", row_count, 0);
        @(negedge ACLK);
        #2 ARESETN = 1'b1;
        #1 check("wready_pre_edge", s_wready, 0);
        @(posedge ACLK);
        #1 check("wready_post_edge", s_wready, 1);
        @(negedge ACLK);

        // Full 8-beat burst
        burst_q = {};
        for (int i = 1; i <= 8; i++) burst_q.push_back(DW'(i));
        send_burst();
        wait_drain();
        check("rowcount_full", row_count, 2);

        // Partial 6-beat burst
        burst_q = {};
        for (int i = 1; i <= 6; i++) burst_q.push_back(DW'(i));
        send_burst();
        wait_drain();
        check("rowcount_partial", row_count, total_rows);

        // Backpressure: 40 words, FIFO fills after 32
        set_mode(0);
        burst_q = {};
        for (int i = 0; i < 40; i++) burst_q.push_back(DW'(32'h1000 + i));
        base = total_rows;
        model_burst();
        for (int i = 0; i < 32; i++) send_word(burst_q[i], 1'b0);
        s_wdata  = burst_q[32];
        s_wvalid = 1'b1;
        s_wlast  = 1'b0;
        check("bp_wready_low", s_wready, 0);
        check("bp_mvalid", m_valid, 1);
        check("bp_rowcount", row_count, base + 8);
        set_mode(1);
        for (int i = 32; i < 40; i++) send_word(burst_q[i], i == 39);
        s_wvalid = 1'b0;
        s_wlast  = 1'b0;
        wait_drain();
        check("bp_rowcount_end", row_count, total_rows);

        // Full FIFO with simultaneous pop; also the single-beat burst
        set_mode(0);
        burst_q = {};
        for (int i = 0; i < 32; i++) burst_q.push_back(DW'(32'h2000 + i));
        send_burst();
        check("full_wready", s_wready, 0);
        @(posedge ACLK);
        #1;
        ready_mode = 1;
        burst_q = {32'hDEADBEEF};
        model_burst();
        s_wdata  = 32'hDEADBEEF;
        s_wvalid = 1'b1;
        s_wlast  = 1'b1;
        @(negedge ACLK);
        check("full_stall", s_wready, 0);
        @(negedge ACLK);
        check("full_accept", s_wready, 1);
        @(negedge ACLK);
        s_wvalid = 1'b0;
        s_wlast  = 1'b0;
        check("full_rowcount", row_count, total_rows);
        wait_drain();

        // Reset mid-burst with a row still queued
        set_mode(0);
        burst_q = {};
        for (int i = 0; i < 4; i++) burst_q.push_back(DW'(32'h50 + i));
        send_burst();
        for (int i = 0; i < 3; i++) send_word(DW'(32'h60 + i), 1'b0);
        s_wvalid = 1'b0;
        check("pre_rst_mvalid", m_valid, 1);
        #2 ARESETN = 1'b0;
        #1;
        check("async_wready", s_wready, 0);
        check("async_mvalid", m_valid, 0);
        check("async_mrow", m_row, 0);
        check("async_mmask", m_mask, 0);
        check("async_mlast", m_last, 0);
        check("async_rowcount", row_count, 0);
        exp_q.delete();
        total_rows = 0;
        ready_mode = 1;
        ARESETN = 1'b1;
        #1 check("rst2_wready_pre", s_wready, 0);
        @(posedge ACLK);
        #1 check("rst2_wready_post", s_wready, 1);
        @(negedge ACLK);
        burst_q = {};
        for (int i = 9; i <= 12; i++) burst_q.push_back(DW'(i));
        send_burst();
        wait_drain();
        check("rst2_rowcount", row_count, 1);

        // Randomized bursts with random consumer stalls
        for (int t = 0; t < 30; t++) begin
            set_mode(int'($urandom_range(1, 2)));
            burst_q = {};
            for (int i = 0; i < int'($urandom_range(1, 12)); i++) burst_q.push_back($urandom);
            send_burst();
            repeat ($urandom_range(0, 2)) @(negedge ACLK);
        end
        set_mode(1);
        wait_drain();
        check("rand_rowcount", row_count, total_rows);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
